ser_bit_feeder: RTL and testbench
=================================

Name: ser_bit_feeder

Overview:
- Parallel-to-serial feeder that sits directly upstream of the 101101 sequence-detector FSM and drives its serial input x.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- A one-word holding register allows gap-free back-to-back words, so the detector also sees patterns that straddle word boundaries.
- Outside a word, the serial line sits at a fixed idle level.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on x_out when no word is being shifted.

Ports:
- Clk, input, 1, rising-edge clock.
- Rst, input, 1, reset; synchronous and active-low (Rst=0 at a rising Clk edge resets the block).
- din, input, WIDTH, parallel word; sampled only on an accepting edge.
- din_valid, input, 1, producer has a word on din.
- din_ready, output, 1, block can take a word this cycle.
- x_out, output, 1, serial bit; connects to the detector's x.
- bit_valid, output, 1, x_out carries a data bit (not idle fill).
- frame_start, output, 1, high during the cycle x_out carries the first bit of a word.
- busy, output, 1, shifter active or hold register occupied.

Behaviour:
- Internal state:
  - shift register sreg[WIDTH-1:0];
  - bit counter bcnt, width ceil(log2 WIDTH);
  - flag active (shifter loaded);
  - hold register hreg[WIDTH-1:0] and flag hold_full.
- All outputs are registered or decoded from registers only. There is no combinational path from din/din_valid to any output.
- Reset (Rst=0 at an edge): active=0, hold_full=0, bcnt=0, x_out=IDLE_BIT, bit_valid=0, frame_start=0.
  - din_ready=0 while Rst=0.
  - Any word in flight or in hold is discarded and never emitted, including a reset that lands mid-word.
- din_ready = Rst & ~hold_full.
- Accept: an edge with din_valid=1 and din_ready=1. Exactly one word is taken per accept. The producer keeps din stable while din_valid=1 and din_ready=0.
- States:
  - IDLE (active=0).
  - SHIFT (active=1). A full hold is a sub-condition of SHIFT.
- IDLE, accept at edge k:
  - din loads into sreg and bcnt=0.
  - From edge k, x_out = first bit, bit_valid=1, frame_start=1.
  - Latency: first bit is visible in the cycle right after the accepting edge.
- SHIFT, each edge: x_out advances to the next bit (per MSB_FIRST), bcnt increments, frame_start=0.
  - Each word occupies exactly WIDTH consecutive cycles.
- SHIFT with hold empty, accept at an edge that is not the last-bit edge: word goes to hreg; hold_full=1; din_ready drops.
- Last-bit edge (bcnt=WIDTH-1), in priority order:
  1. If hold_full: hreg→sreg, hold_full=0, frame_start=1, bit_valid stays 1 (no gap).
  2. Else if accept this edge: din→sreg directly, frame_start=1 (no gap).
  3. Else: go to IDLE; x_out=IDLE_BIT, bit_valid=0.
- Hold full on a last-bit edge: din_ready is 0, so no simultaneous accept is possible. Only one word can be in hold.
- busy = active | hold_full.
- No word is ever dropped, duplicated or reordered.

Test Plan:
- Single word: WIDTH=8, MSB_FIRST=1, IDLE_BIT=0, Rst released, din=8'hB4 accepted at edge k.
  - Required: x_out = 1,0,1,1,0,1,0,0 on cycles k..k+7; frame_start=1 only at cycle k; bit_valid=0 and x_out=0 from edge k+8.
  - Detector attached: z asserts once.
- Back-to-back: din_valid held high with A=8'hB4, then B=8'h2D.
  - Required: A accepted at edge 0; B accepted at edge 1; din_ready=0 for edges 2..7, back to 1 after edge 8.
  - Required: x_out is 16 contiguous bits (A then B); bit_valid never drops; frame_start pulses at edges 0 and 8.
- Straddling pattern: words 8'h05 then 8'hA0, back-to-back.
  - Required: serial stream ...0101 1010... carries 101101 across the word boundary; detector z asserts once.
- Gap: word A, then din_valid low for 3 cycles, then word B.
  - Required: x_out=IDLE_BIT and bit_valid=0 between the words; B starts with frame_start=1.
- Reset mid-operation: Rst=0 at bit 4 of word A while B is in hold.
  - Required: next cycle x_out=IDLE_BIT, bit_valid=0, busy=0; din_ready=0 while Rst=0, then 1.
  - Required: neither A nor B resumes after reset.
- LSB-first: MSB_FIRST=0, IDLE_BIT=1, din=8'hB4.
  - Required: x_out = 0,0,1,0,1,1,0,1, then idle level 1.

Source files
------------

// File: rtl/ser_bit_feeder_if.sv
// Word-in / bit-out bundle between a word producer and the serial feeder.
// The producer side (master) drives din/din_valid and observes everything else.
interface ser_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x_out, bit_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x_out, bit_valid, frame_start, busy
  );
endinterface

// File: rtl/ser_bit_feeder.sv
// Parallel-to-serial feeder with a one-word hold register so consecutive words
// are shifted out with no idle gap between them.
module ser_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  ser_bit_feeder_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [WIDTH-1:0] hreg_reg, hreg_next;
  logic [CW-1:0]    bcnt_reg, bcnt_next;
  logic             hold_full_reg, hold_full_next;
  logic             frame_start_reg, frame_start_next;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign bus.din_ready = Rst & ~hold_full_reg;
  assign accept        = bus.din_valid & bus.din_ready;
  assign shifted       = MSB_FIRST ? (sreg_reg << 1) : (sreg_reg >> 1);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg       <= IDLE;
      sreg_reg        <= '0;
      hreg_reg        <= '0;
      bcnt_reg        <= '0;
      hold_full_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sreg_reg        <= sreg_next;
      hreg_reg        <= hreg_next;
      bcnt_reg        <= bcnt_next;
      hold_full_reg   <= hold_full_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sreg_next        = sreg_reg;
    hreg_next        = hreg_reg;
    bcnt_next        = bcnt_reg;
    hold_full_next   = hold_full_reg;
    frame_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          sreg_next        = bus.din;
          bcnt_next        = '0;
          frame_start_next = 1'b1;
          state_next       = SHIFT;
        end
      end
      SHIFT: begin
        if (bcnt_reg == LAST) begin
          // Held word wins over a fresh accept; din_ready is low then anyway.
          bcnt_next = '0;
          if (hold_full_reg) begin
            sreg_next        = hreg_reg;
            hold_full_next   = 1'b0;
            frame_start_next = 1'b1;
          end else if (accept) begin
            sreg_next        = bus.din;
            frame_start_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          sreg_next = shifted;
          bcnt_next = bcnt_reg + 1'b1;
          if (accept) begin
            hreg_next      = bus.din;
            hold_full_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.x_out       = (state_reg == SHIFT) ?
                           (MSB_FIRST ? sreg_reg[WIDTH-1] : sreg_reg[0]) : IDLE_BIT;
  assign bus.bit_valid   = (state_reg == SHIFT);
  assign bus.frame_start = frame_start_reg;
  assign bus.busy        = (state_reg == SHIFT) | hold_full_reg;
endmodule

// File: tb/tb_ser_bit_feeder.sv
// Bench for ser_bit_feeder: scoreboarded MSB-first instance with a 101101
// pattern counter on its serial line, plus an LSB-first/idle-high instance.
module tb_ser_bit_feeder;
  logic Clk;
  logic Rst;

  ser_bit_feeder_if #(.WIDTH(8)) b0 ();
  ser_bit_feeder_if #(.WIDTH(8)) b1 ();

  ser_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .Clk(Clk), .Rst(Rst), .bus(b0)
  );
  ser_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .Clk(Clk), .Rst(Rst), .bus(b1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic b;
    logic first;
  } exp_t;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         mode;   // 0 single word, 1 back-to-back, 2 with idle gap
    int         exp_z;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   zcount = 0;
  logic [5:0] hist = 6'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor and detector model on u0's serial line.
  always @(negedge Clk) begin
    exp_t e;
    hist = {hist[4:0], b0.x_out};
    if (hist == 6'b101101) zcount++;
    if (b0.bit_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_bit: got bit_valid=1 with nothing owed at %0t", $time);
      end else begin
        e = q.pop_front();
        check("bit", {31'd0, b0.x_out}, {31'd0, e.b});
        check("frame_start", {31'd0, b0.frame_start}, {31'd0, e.first});
      end
    end else begin
      check("idle_level", {31'd0, b0.x_out}, 32'd0);
      check("idle_frame_start", {31'd0, b0.frame_start}, 32'd0);
      check("no_gap_pending", q.size(), 32'd0);
    end
  end

  task automatic send(input logic [7:0] w, input bit keep, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    b0.din       = w;
    b0.din_valid = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge Clk);
      if (b0.din_ready) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      b0.din_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    for (int i = 7; i >= 0; i--) q.push_back('{b: w[i], first: (i == 7)});
    #1;
    if (!keep) b0.din_valid = 1'b0;
    $display("[TB] word %02h accepted after %0d wait cycles", w, waits);
  endtask

  initial begin
    vec_t vecs[5];
    int   waits;
    int   z0;
    logic [7:0] lsb_word;

    vecs[0] = '{8'hB4, 8'h00, 0, 1};
    vecs[1] = '{8'hB4, 8'h2D, 1, 2};
    vecs[2] = '{8'h05, 8'hA0, 1, 1};
    vecs[3] = '{8'hB4, 8'h2D, 2, 2};
    vecs[4] = '{8'hFF, 8'h00, 1, 0};

    Rst = 1'b0;
    b0.din = '0; b0.din_valid = 1'b0;
    b1.din = '0; b1.din_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_x_out", {31'd0, b0.x_out}, 32'd0);
    check("rst_bit_valid", {31'd0, b0.bit_valid}, 32'd0);
    check("rst_frame_start", {31'd0, b0.frame_start}, 32'd0);
    check("rst_busy", {31'd0, b0.busy}, 32'd0);
    check("rst_din_ready", {31'd0, b0.din_ready}, 32'd0);
    check("rst_x_out_lsb", {31'd0, b1.x_out}, 32'd1);
    Rst = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, b0.din_ready}, 32'd1);
    @(posedge Clk); #1;

    for (int v = 0; v < 5; v++) begin
      z0 = zcount;
      send(vecs[v].w0, vecs[v].mode == 1, waits);
      check("a_accept_wait", waits, 32'd0);
      if (vecs[v].mode == 2) begin
        repeat (11) @(posedge Clk);
        #1;
        check("gap_bit_valid", {31'd0, b0.bit_valid}, 32'd0);
        check("gap_busy", {31'd0, b0.busy}, 32'd0);
      end
      if (vecs[v].mode != 0) begin
        send(vecs[v].w1, 1'b0, waits);
        check("b_accept_wait", waits, 32'd0);
        if (vecs[v].mode == 1) begin
          check("hold_ready_low", {31'd0, b0.din_ready}, 32'd0);
          check("hold_busy", {31'd0, b0.busy}, 32'd1);
          repeat (6) @(posedge Clk); #1;
          check("ready_low_edge7", {31'd0, b0.din_ready}, 32'd0);
          @(posedge Clk); #1;
          check("ready_back_edge8", {31'd0, b0.din_ready}, 32'd1);
        end
      end
      repeat (20) @(posedge Clk);
      #1;
      check("drained", q.size(), 32'd0);
      check("z_count", zcount - z0, vecs[v].exp_z);
      $display("[TB] vector %0d words %02h/%02h mode %0d z=%0d", v, vecs[v].w0, vecs[v].w1,
               vecs[v].mode, zcount - z0);
    end

    // Reset while word A is on bit 4 and word B sits in hold.
    send(8'hB4, 1'b1, waits);
    send(8'h2D, 1'b0, waits);
    check("rst_test_hold_busy", {31'd0, b0.busy}, 32'd1);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    q.delete();
    #1;
    check("midrst_x_out", {31'd0, b0.x_out}, 32'd0);
    check("midrst_bit_valid", {31'd0, b0.bit_valid}, 32'd0);
    check("midrst_busy", {31'd0, b0.busy}, 32'd0);
    check("midrst_ready", {31'd0, b0.din_ready}, 32'd0);
    @(posedge Clk); #1;
    check("midrst_ready2", {31'd0, b0.din_ready}, 32'd0);
    Rst = 1'b1;
    #1;
    check("postrst_ready", {31'd0, b0.din_ready}, 32'd1);
    repeat (15) @(posedge Clk);
    #1;
    check("postrst_no_resume", {31'd0, b0.busy}, 32'd0);
    $display("[TB] mid-word reset done");

    // LSB-first instance with idle-high line.
    lsb_word = 8'hB4;
    b1.din = lsb_word;
    b1.din_valid = 1'b1;
    @(negedge Clk);
    check("lsb_ready", {31'd0, b1.din_ready}, 32'd1);
    @(posedge Clk); #1;
    b1.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit", {31'd0, b1.x_out}, {31'd0, lsb_word[i]});
      check("lsb_valid", {31'd0, b1.bit_valid}, 32'd1);
      check("lsb_frame_start", {31'd0, b1.frame_start}, (i == 0) ? 32'd1 : 32'd0);
      @(posedge Clk); #1;
    end
    check("lsb_idle_level", {31'd0, b1.x_out}, 32'd1);
    check("lsb_idle_valid", {31'd0, b1.bit_valid}, 32'd0);
    $display("[TB] lsb-first word %02h done", lsb_word);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
